// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register of the 5-stage MIPS pipeline.
// Stalls freeze the front end; a taken branch or jump redirects the PC and flushes IF/ID.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LWStall,
  input  logic             BRStall,
  input  logic             PCSrcD,
  input  logic [31:0]      PCBranchD,
  input  logic             JumpD,
  input  logic [31:0]      PCJumpD,
  input  logic [31:0]      InstrF,
  output logic [31:0]      PCF,
  output logic [31:0]      InstrD,
  output logic [31:0]      PCPlus4D,
  output logic             ValidD,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [31:0]      pc_r;
  logic [31:0]      instr_r;
  logic [31:0]      pcplus4_r;
  logic             valid_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  logic [31:0]      pcplus4_s;
  logic             stall_s;
  logic             flush_s;
  logic [31:0]      pc_next_s;
  logic [31:0]      instr_next_s;
  logic [31:0]      pcplus4_next_s;
  logic             valid_next_s;
  logic [CNT_W-1:0] stall_cnt_next_s;
  logic [CNT_W-1:0] flush_cnt_next_s;

  // Next-state selection; a stall masks any redirect, and branch beats jump.
  always_comb begin
    pcplus4_s      = pc_r + 32'd4;
    stall_s        = LWStall | BRStall;
    flush_s        = 1'b0;
    pc_next_s      = pc_r;
    instr_next_s   = instr_r;
    pcplus4_next_s = pcplus4_r;
    valid_next_s   = valid_r;
    if (stall_s) begin
      pc_next_s = pc_r;
    end else if (PCSrcD) begin
      pc_next_s = PCBranchD;
      flush_s   = 1'b1;
    end else if (JumpD) begin
      pc_next_s = PCJumpD;
      flush_s   = 1'b1;
    end else begin
      pc_next_s      = pcplus4_s;
      instr_next_s   = InstrF;
      pcplus4_next_s = pcplus4_s;
      valid_next_s   = 1'b1;
    end
    if (flush_s) begin
      instr_next_s   = NOP_INSTR;
      pcplus4_next_s = 32'h0000_0000;
      valid_next_s   = 1'b0;
    end else begin
      instr_next_s   = instr_next_s;
    end
  end

  // Saturating performance counters: they stick at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_next_s = stall_cnt_r;
    flush_cnt_next_s = flush_cnt_r;
    if (stall_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_next_s = stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_next_s = stall_cnt_r;
    end
    if (flush_s && (flush_cnt_r != CNT_MAX)) begin
      flush_cnt_next_s = flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      flush_cnt_next_s = flush_cnt_r;
    end
  end

  // PC, IF/ID register and counters; reset discards any in-flight stall or redirect.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_r        <= RESET_PC;
      instr_r     <= NOP_INSTR;
      pcplus4_r   <= 32'h0000_0000;
      valid_r     <= 1'b0;
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      pc_r        <= pc_next_s;
      instr_r     <= instr_next_s;
      pcplus4_r   <= pcplus4_next_s;
      valid_r     <= valid_next_s;
      stall_cnt_r <= stall_cnt_next_s;
      flush_cnt_r <= flush_cnt_next_s;
    end
  end

  assign PCF      = pc_r;
  assign InstrD   = instr_r;
  assign PCPlus4D = pcplus4_r;
  assign ValidD   = valid_r;
  assign StallCnt = stall_cnt_r;
  assign FlushCnt = flush_cnt_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: default instance, a wrap-around
// RESET_PC instance and a narrow-counter instance all share the control inputs.
module tb_fetch_stage;

  logic        CLK;
  logic        RST;
  logic        LWStall;
  logic        BRStall;
  logic        PCSrcD;
  logic [31:0] PCBranchD;
  logic        JumpD;
  logic [31:0] PCJumpD;

  logic [31:0] pcf0, instrf0, instrd0, pcp4d0;
  logic        validd0;
  logic [15:0] stallcnt0, flushcnt0;

  logic [31:0] pcf1, instrf1, instrd1, pcp4d1;
  logic        validd1;
  logic [15:0] stallcnt1, flushcnt1;

  logic [31:0] pcf2, instrf2, instrd2, pcp4d2;
  logic        validd2;
  logic [1:0]  stallcnt2, flushcnt2;

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return a + 32'h1000_0000;
  endfunction

  assign instrf0 = imem(pcf0);
  assign instrf1 = imem(pcf1);
  assign instrf2 = imem(pcf2);

  fetch_stage dut0 (
    .CLK(CLK), .RST(RST), .LWStall(LWStall), .BRStall(BRStall),
    .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .JumpD(JumpD), .PCJumpD(PCJumpD),
    .InstrF(instrf0), .PCF(pcf0), .InstrD(instrd0), .PCPlus4D(pcp4d0),
    .ValidD(validd0), .StallCnt(stallcnt0), .FlushCnt(flushcnt0)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .CLK(CLK), .RST(RST), .LWStall(LWStall), .BRStall(BRStall),
    .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .JumpD(JumpD), .PCJumpD(PCJumpD),
    .InstrF(instrf1), .PCF(pcf1), .InstrD(instrd1), .PCPlus4D(pcp4d1),
    .ValidD(validd1), .StallCnt(stallcnt1), .FlushCnt(flushcnt1)
  );

  fetch_stage #(.CNT_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .LWStall(LWStall), .BRStall(BRStall),
    .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .JumpD(JumpD), .PCJumpD(PCJumpD),
    .InstrF(instrf2), .PCF(pcf2), .InstrD(instrd2), .PCPlus4D(pcp4d2),
    .ValidD(validd2), .StallCnt(stallcnt2), .FlushCnt(flushcnt2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                            input logic [31:0] p4, input logic v);
    check({tag, ".PCF"}, pcf0, pc);
    check({tag, ".InstrD"}, instrd0, ins);
    check({tag, ".PCPlus4D"}, pcp4d0, p4);
    check({tag, ".ValidD"}, {31'd0, validd0}, {31'd0, v});
  endtask

  initial begin
    RST = 1'b1; LWStall = 1'b0; BRStall = 1'b0; PCSrcD = 1'b0; JumpD = 1'b0;
    PCBranchD = 32'h0000_0000; PCJumpD = 32'h0000_0000;
    step();
    check_ifid("rst", 32'h0, 32'h0, 32'h0, 1'b0);
    check("rst.StallCnt", {16'd0, stallcnt0}, 32'd0);
    check("rst.FlushCnt", {16'd0, flushcnt0}, 32'd0);
    check("rst.PCF_wrap", pcf1, 32'hFFFF_FFFC);

    RST = 1'b0;
    step();
    check_ifid("seq1", 32'h4, 32'h1000_0000, 32'h4, 1'b1);
    check("wrap.PCF", pcf1, 32'h0);
    check("wrap.PCPlus4D", pcp4d1, 32'h0);
    check("wrap.InstrD", instrd1, 32'h0FFF_FFFC);
    step();
    check_ifid("seq2", 32'h8, 32'h1000_0004, 32'h8, 1'b1);

    // load-use stall for two cycles at PCF=8
    LWStall = 1'b1;
    step();
    check_ifid("lw1", 32'h8, 32'h1000_0004, 32'h8, 1'b1);
    step();
    check_ifid("lw2", 32'h8, 32'h1000_0004, 32'h8, 1'b1);
    check("lw.StallCnt", {16'd0, stallcnt0}, 32'd2);
    LWStall = 1'b0;
    step();
    check_ifid("resume", 32'hC, 32'h1000_0008, 32'hC, 1'b1);
    step();
    check_ifid("seq4", 32'h10, 32'h1000_000C, 32'h10, 1'b1);

    // taken branch at PCF=0x10
    PCSrcD = 1'b1; PCBranchD = 32'h0000_0040;
    step();
    check_ifid("br", 32'h40, 32'h0, 32'h0, 1'b0);
    check("br.FlushCnt", {16'd0, flushcnt0}, 32'd1);
    PCSrcD = 1'b0;
    step();
    check_ifid("br.tgt", 32'h44, 32'h1000_0040, 32'h44, 1'b1);

    // branch during BRStall is ignored, then taken once the stall releases
    BRStall = 1'b1; PCSrcD = 1'b1; PCBranchD = 32'h0000_0200;
    step();
    check_ifid("brst", 32'h44, 32'h1000_0040, 32'h44, 1'b1);
    check("brst.StallCnt", {16'd0, stallcnt0}, 32'd3);
    check("brst.FlushCnt", {16'd0, flushcnt0}, 32'd1);
    check("sat.StallCnt3", {30'd0, stallcnt2}, 32'd3);
    BRStall = 1'b0;
    step();
    check_ifid("brst.go", 32'h200, 32'h0, 32'h0, 1'b0);
    check("brst.FlushCnt2", {16'd0, flushcnt0}, 32'd2);

    // branch and jump together: branch wins, single flush
    PCBranchD = 32'h0000_0080; JumpD = 1'b1; PCJumpD = 32'h0000_0100;
    step();
    check_ifid("bj", 32'h80, 32'h0, 32'h0, 1'b0);
    check("bj.FlushCnt", {16'd0, flushcnt0}, 32'd3);
    PCSrcD = 1'b0; JumpD = 1'b0;
    step();
    check_ifid("bj.tgt", 32'h84, 32'h1000_0080, 32'h84, 1'b1);

    // jump alone to an unaligned target
    JumpD = 1'b1; PCJumpD = 32'h0000_0103;
    step();
    check_ifid("jmp", 32'h103, 32'h0, 32'h0, 1'b0);
    check("jmp.FlushCnt", {16'd0, flushcnt0}, 32'd4);
    check("sat.FlushCnt", {30'd0, flushcnt2}, 32'd3);
    JumpD = 1'b0;

    // five more stall cycles: narrow counter stays saturated
    LWStall = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("sat.StallCnt", {30'd0, stallcnt2}, 32'd3);
    check("stall5.StallCnt", {16'd0, stallcnt0}, 32'd8);
    check("stall5.PCF", pcf0, 32'h103);

    // reset while stalled
    RST = 1'b1;
    step();
    check_ifid("rst2", 32'h0, 32'h0, 32'h0, 1'b0);
    check("rst2.StallCnt", {16'd0, stallcnt0}, 32'd0);
    check("rst2.FlushCnt", {16'd0, flushcnt0}, 32'd0);
    RST = 1'b0; LWStall = 1'b0;
    step();
    check_ifid("rst2.seq", 32'h4, 32'h1000_0000, 32'h4, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline.
- Holds the PC and computes PC+4, then selects the next PC from sequential, branch or jump targets.
- Latches the fetched instruction into the decode stage.
- Consumes the hazard unit's LWStall/BRStall to freeze the front end, and the decode stage's branch/jump resolution to redirect and flush.
- Includes saturating stall and flush event counters for performance debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word injected into decode on flush/reset (sll $0,$0,0)
CNT_W, 16, width of the stall and flush performance counters

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  synchronous, active-high reset
LWStall  input  1  load-use stall request from hazard unit
BRStall  input  1  branch-operand stall request from hazard unit
PCSrcD  input  1  branch in decode resolved taken
PCBranchD  input  32  branch target computed in decode
JumpD  input  1  jump in decode
PCJumpD  input  32  jump target computed in decode
InstrF  input  32  instruction memory read data for PCF (combinational, same cycle)
PCF  output  32  current fetch address to instruction memory
InstrD  output  32  IF/ID registered instruction
PCPlus4D  output  32  IF/ID registered PC+4 of InstrD
ValidD  output  1  InstrD is a real fetched instruction, not a bubble
StallCnt  output  CNT_W  cycles in which the front end was frozen
FlushCnt  output  CNT_W  number of IF/ID flushes performed

Behaviour:
- Reset (RST=1 at a rising edge, has priority over everything):
  - PCF=RESET_PC, InstrD=NOP_INSTR, PCPlus4D=0, ValidD=0, StallCnt=0, FlushCnt=0.
  - Reset asserted mid-stall or mid-redirect discards all pending state.
- PCPlus4F = PCF + 4, 32-bit modulo. 32'hFFFF_FFFC wraps to 0 without error.
- stall = LWStall | BRStall.
- Per-edge priority when RST=0:
  1. stall=1:
     - PCF, InstrD, PCPlus4D and ValidD all hold.
     - PCSrcD/JumpD are ignored. The stalled branch/jump stays in decode and re-asserts its redirect in the first unstalled cycle.
     - StallCnt increments.
  2. PCSrcD=1:
     - PCF<=PCBranchD.
     - Flush: InstrD<=NOP_INSTR, PCPlus4D<=0, ValidD<=0.
     - FlushCnt increments.
  3. JumpD=1 (PCSrcD=0):
     - PCF<=PCJumpD.
     - Same flush as a taken branch; FlushCnt increments.
     - If PCSrcD and JumpD are both 1, the branch wins.
  4. Otherwise:
     - PCF<=PCPlus4F.
     - InstrD<=InstrF, PCPlus4D<=PCPlus4F, ValidD<=1.
- Redirect latency: the target appears on PCF one cycle after the redirect edge. Exactly one fetched instruction (the one at PCF during the redirect cycle) is discarded. No branch delay slot is executed.
- Counters saturate at all-ones and never wrap.
- Redirect inputs are only sampled when stall=0. No internal state remembers a suppressed redirect.
- Outputs are all registered, except PCF, which is the PC register output directly. No combinational path from inputs to outputs.
- Targets are not alignment-checked; the low 2 bits pass through unchanged.

Test Plan:
- Reset, then 4 free-running cycles with InstrF=PCF-derived pattern:
  - PCF sequence 0,4,8,12,16.
  - InstrD lags by one cycle, PCPlus4D=4,8,12,16, ValidD=1 from the second edge.
- LWStall=1 for 2 cycles at PCF=8:
  - PCF holds 8, InstrD/PCPlus4D hold, StallCnt=2.
  - Fetch resumes at 12 on release.
- PCSrcD=1, PCBranchD=0x40 at PCF=0x10:
  - Next PCF=0x40, InstrD=NOP_INSTR, ValidD=0, FlushCnt=1.
  - The following edge loads InstrF fetched at 0x40 with ValidD=1.
- BRStall=1 and PCSrcD=1 in the same cycle, then BRStall=0 with PCSrcD=1:
  - First edge holds everything, StallCnt+1, no flush.
  - Second edge redirects and flushes.
- PCSrcD=1 (target 0x80) and JumpD=1 (target 0x100) together:
  - PCF=0x80, single flush.
- Boundary checks:
  - RESET_PC=32'hFFFF_FFFC: next PCF=0, PCPlus4D=0.
  - CNT_W=2 with 5 stall cycles: StallCnt saturates at 3.
  - RST asserted during a stall: all outputs return to reset values next edge.
